// File: rtl/acc_dispatch_arbiter_pkg.sv
// Shared types and helpers for the Ara accelerator-port dispatch arbiter.
package acc_dispatch_arbiter_pkg;

    localparam int AccIdW   = 4;
    localparam int AccXlen  = 64;

    typedef logic [AccIdW-1:0] acc_id_t;

    typedef struct packed {
        logic [31:0]        insn;
        logic [AccXlen-1:0] rs1;
        logic [AccXlen-1:0] rs2;
        logic               resp_exp;
    } disp_req_t;

    // Round-robin successor of idx among n requesters.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/acc_dispatch_id_fifo.sv
// Synchronous FIFO holding requester IDs of response-expecting requests.
module acc_dispatch_id_fifo
    import acc_dispatch_arbiter_pkg::*;
#(
    parameter  int DATA_W = AccIdW,
    parameter  int DEPTH  = 8,
    localparam int PtrW   = $clog2(DEPTH),
    localparam int CntW   = $clog2(DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [CntW-1:0]   count_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    assign full_o  = (cnt_q == CntW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign data_o  = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = push_i ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_i  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d    = cnt_q;
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full_o));
    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni) !(pop_i && empty_o));

endmodule

// File: rtl/acc_dispatch_arbiter.sv
// Round-robin sharing of Ara's accelerator port among scalar requesters,
// with in-order response routing back to the issuing requester.
module acc_dispatch_arbiter
    import acc_dispatch_arbiter_pkg::*;
#(
    parameter  int NumReq   = 2,
    parameter  int MaxOutst = 8,
    parameter  int XLEN     = 64,
    localparam int IdW      = $clog2(NumReq),
    localparam int CntW     = $clog2(MaxOutst) + 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NumReq-1:0]          req_valid_i,
    output logic [NumReq-1:0]          req_ready_o,
    input  logic [NumReq-1:0][31:0]    req_insn_i,
    input  logic [NumReq-1:0][XLEN-1:0] req_rs1_i,
    input  logic [NumReq-1:0][XLEN-1:0] req_rs2_i,
    input  logic [NumReq-1:0]          req_resp_exp_i,
    output logic                       acc_req_valid_o,
    input  logic                       acc_req_ready_i,
    output logic [31:0]                acc_insn_o,
    output logic [XLEN-1:0]            acc_rs1_o,
    output logic [XLEN-1:0]            acc_rs2_o,
    input  logic                       acc_resp_valid_i,
    output logic                       acc_resp_ready_o,
    input  logic [XLEN-1:0]            acc_resp_result_i,
    input  logic                       acc_resp_error_i,
    output logic [NumReq-1:0]          resp_valid_o,
    input  logic [NumReq-1:0]          resp_ready_i,
    output logic [XLEN-1:0]            resp_result_o,
    output logic                       resp_error_o,
    output logic [CntW-1:0]            outst_cnt_o,
    output logic                       idle_o,
    output logic                       err_spurious_o
);

    logic [IdW-1:0]    rr_q, rr_d;
    logic              lock_q, lock_d;
    logic [IdW-1:0]    locked_id_q, locked_id_d;
    logic              err_spurious_q, err_spurious_d;

    logic              fifo_full, fifo_empty;
    logic [IdW-1:0]    head_id;
    logic              push, pop, req_hs;
    logic [NumReq-1:0] eligible;
    logic              win_found;
    logic [IdW-1:0]    win_id;

    acc_dispatch_id_fifo #(
        .DATA_W (IdW),
        .DEPTH  (MaxOutst)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (win_id),
        .pop_i   (pop),
        .data_o  (head_id),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (outst_cnt_o)
    );

    // A held grant bypasses eligibility: it was eligible when it locked and
    // nothing else can push while it waits, so the FIFO cannot fill under it.
    always_comb begin
        int idx;
        idx       = 0;
        eligible  = req_valid_i & ~(req_resp_exp_i & {NumReq{fifo_full}});
        win_found = 1'b0;
        win_id    = '0;
        if (lock_q) begin
            win_found = 1'b1;
            win_id    = locked_id_q;
        end else begin
            for (int k = 0; k < NumReq; k++) begin
                idx = int'(rr_q) + k;
                if (idx >= NumReq) idx = idx - NumReq;
                if (!win_found && eligible[idx]) begin
                    win_found = 1'b1;
                    win_id    = IdW'(idx);
                end
            end
        end
    end

    always_comb begin
        req_ready_o     = '0;
        acc_req_valid_o = win_found;
        acc_insn_o      = '0;
        acc_rs1_o       = '0;
        acc_rs2_o       = '0;
        if (win_found) begin
            req_ready_o[win_id] = acc_req_ready_i;
            acc_insn_o          = req_insn_i[win_id];
            acc_rs1_o           = req_rs1_i[win_id];
            acc_rs2_o           = req_rs2_i[win_id];
        end
    end

    assign req_hs = win_found && acc_req_ready_i;
    assign push   = req_hs && req_resp_exp_i[win_id];

    // With nothing outstanding, any response is sunk and flagged instead of routed.
    always_comb begin
        resp_valid_o     = '0;
        acc_resp_ready_o = acc_resp_valid_i;
        if (!fifo_empty) begin
            resp_valid_o[head_id] = acc_resp_valid_i;
            acc_resp_ready_o      = resp_ready_i[head_id];
        end
    end

    assign pop           = !fifo_empty && acc_resp_valid_i && resp_ready_i[head_id];
    assign resp_result_o = acc_resp_result_i;
    assign resp_error_o  = acc_resp_error_i;
    assign idle_o        = !acc_req_valid_o && (outst_cnt_o == '0);
    assign err_spurious_o = err_spurious_q;

    always_comb begin
        rr_d           = req_hs ? IdW'(rr_next(int'(win_id), NumReq)) : rr_q;
        lock_d         = win_found && !acc_req_ready_i;
        locked_id_d    = win_found ? win_id : locked_id_q;
        err_spurious_d = err_spurious_q || (acc_resp_valid_i && fifo_empty);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q           <= '0;
            lock_q         <= 1'b0;
            locked_id_q    <= '0;
            err_spurious_q <= 1'b0;
        end else begin
            rr_q           <= rr_d;
            lock_q         <= lock_d;
            locked_id_q    <= locked_id_d;
            err_spurious_q <= err_spurious_d;
        end
    end

    a_req_ready_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(req_ready_o));
    a_resp_valid_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(resp_valid_o));
    a_locked_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (acc_req_valid_o && !acc_req_ready_i) |=>
        (acc_req_valid_o && $stable(acc_insn_o) && $stable(acc_rs1_o) && $stable(acc_rs2_o)));

endmodule

// File: tb/tb_acc_dispatch_arbiter.sv
// Directed bench for acc_dispatch_arbiter with NumReq=2, MaxOutst=8, XLEN=64.
module tb_acc_dispatch_arbiter;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       req_valid, req_ready, req_resp_exp;
    logic [1:0][31:0] req_insn;
    logic [1:0][63:0] req_rs1, req_rs2;
    logic             acc_req_valid, acc_req_ready;
    logic [31:0]      acc_insn;
    logic [63:0]      acc_rs1, acc_rs2;
    logic             acc_resp_valid, acc_resp_ready, acc_resp_error;
    logic [63:0]      acc_resp_result;
    logic [1:0]       resp_valid, resp_ready;
    logic [63:0]      resp_result;
    logic             resp_error;
    logic [3:0]       outst_cnt;
    logic             idle, err_spurious;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    acc_dispatch_arbiter #(.NumReq(2), .MaxOutst(8), .XLEN(64)) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .req_valid_i       (req_valid),
        .req_ready_o       (req_ready),
        .req_insn_i        (req_insn),
        .req_rs1_i         (req_rs1),
        .req_rs2_i         (req_rs2),
        .req_resp_exp_i    (req_resp_exp),
        .acc_req_valid_o   (acc_req_valid),
        .acc_req_ready_i   (acc_req_ready),
        .acc_insn_o        (acc_insn),
        .acc_rs1_o         (acc_rs1),
        .acc_rs2_o         (acc_rs2),
        .acc_resp_valid_i  (acc_resp_valid),
        .acc_resp_ready_o  (acc_resp_ready),
        .acc_resp_result_i (acc_resp_result),
        .acc_resp_error_i  (acc_resp_error),
        .resp_valid_o      (resp_valid),
        .resp_ready_i      (resp_ready),
        .resp_result_o     (resp_result),
        .resp_error_o      (resp_error),
        .outst_cnt_o       (outst_cnt),
        .idle_o            (idle),
        .err_spurious_o    (err_spurious)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid       = '0;
        req_resp_exp    = '0;
        acc_req_ready   = 1'b0;
        acc_resp_valid  = 1'b0;
        acc_resp_result = '0;
        acc_resp_error  = 1'b0;
        resp_ready      = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        req_insn = '0; req_rs1 = '0; req_rs2 = '0;
        repeat (2) @(posedge clk);
        #2;
        checks++; if (outst_cnt !== 4'd0) begin errors++; $display("FAIL reset_outst got %0d want 0", outst_cnt); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %b want 1", idle); end
        checks++; if (err_spurious !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err_spurious); end
        checks++; if ({acc_req_valid, req_ready, resp_valid, acc_resp_ready} !== 6'b0) begin
            errors++; $display("FAIL reset_handshakes got %b want 000000", {acc_req_valid, req_ready, resp_valid, acc_resp_ready}); end
        checks++; if (acc_insn !== 32'h0) begin errors++; $display("FAIL reset_insn got %h want 0", acc_insn); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        req_insn[0] = 32'h0200_7057; req_rs1[0] = 64'h1111; req_rs2[0] = 64'h2222;
        req_valid = 2'b01; acc_req_ready = 1'b1;
        #1;
        checks++; if (acc_insn !== 32'h0200_7057) begin errors++; $display("FAIL single_insn got %h want 02007057", acc_insn); end
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready got %b want 01", req_ready); end
        checks++; if ({acc_req_valid, acc_rs1, acc_rs2} !== {1'b1, 64'h1111, 64'h2222}) begin
            errors++; $display("FAIL single_ops got v=%b rs1=%h rs2=%h want 1/1111/2222", acc_req_valid, acc_rs1, acc_rs2); end
        step();
        req_valid = 2'b00;
        #1;
        checks++; if (outst_cnt !== 4'd0) begin errors++; $display("FAIL single_outst got %0d want 0", outst_cnt); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL single_idle got %b want 1", idle); end
    endtask

    // Previous winner was req0, so the sequence starts at req1.
    task automatic test_fairness();
        int exp_g = 1;
        int n0 = 0;
        int n1 = 0;
        req_insn[0] = 32'hA000_0000; req_insn[1] = 32'hB000_0000;
        req_valid = 2'b11; acc_req_ready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            #1;
            checks++;
            if (req_ready !== (2'b01 << exp_g)) begin
                errors++; $display("FAIL fair_grant cycle %0d got %b want %b", c, req_ready, 2'b01 << exp_g);
            end
            if (req_ready === 2'b01) n0++;
            else if (req_ready === 2'b10) n1++;
            exp_g = 1 - exp_g;
            step();
        end
        req_valid = 2'b00;
        checks++; if (n0 != 50) begin errors++; $display("FAIL fair_count0 got %0d want 50", n0); end
        checks++; if (n1 != 50) begin errors++; $display("FAIL fair_count1 got %0d want 50", n1); end
    endtask

    // rr points at req1 here, so only the lock keeps req0 selected.
    task automatic test_lock();
        req_insn[0] = 32'h0000_1234; req_insn[1] = 32'h0000_5678;
        req_valid = 2'b01; acc_req_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if ({acc_req_valid, req_ready, acc_insn} !== {1'b1, 2'b00, 32'h0000_1234}) begin
                errors++; $display("FAIL lock_hold cycle %0d got v=%b rdy=%b insn=%h want 1/00/00001234", c, acc_req_valid, req_ready, acc_insn);
            end
            step();
            req_valid = 2'b11;
        end
        acc_req_ready = 1'b1;
        #1;
        checks++; if ({req_ready, acc_insn} !== {2'b01, 32'h0000_1234}) begin
            errors++; $display("FAIL lock_release got rdy=%b insn=%h want 01/00001234", req_ready, acc_insn); end
        step();
        req_valid = 2'b10;
        #1;
        checks++; if ({req_ready, acc_insn} !== {2'b10, 32'h0000_5678}) begin
            errors++; $display("FAIL lock_next got rdy=%b insn=%h want 10/00005678", req_ready, acc_insn); end
        step();
        clear_inputs();
    endtask

    task automatic test_routing();
        acc_req_ready = 1'b1;
        req_valid = 2'b10; req_resp_exp = 2'b10;
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL route_issue1 got %b want 10", req_ready); end
        step();
        req_valid = 2'b01; req_resp_exp = 2'b01;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL route_issue0 got %b want 01", req_ready); end
        step();
        clear_inputs();
        #1;
        checks++; if (outst_cnt !== 4'd2) begin errors++; $display("FAIL route_cnt2 got %0d want 2", outst_cnt); end
        acc_resp_valid = 1'b1; acc_resp_result = 64'hAA; resp_ready = 2'b11;
        #1;
        checks++; if ({resp_valid, resp_result, acc_resp_ready} !== {2'b10, 64'hAA, 1'b1}) begin
            errors++; $display("FAIL route_resp1 got v=%b res=%h rdy=%b want 10/aa/1", resp_valid, resp_result, acc_resp_ready); end
        step();
        acc_resp_result = 64'hBB;
        #1;
        checks++; if ({resp_valid, resp_result, outst_cnt} !== {2'b01, 64'hBB, 4'd1}) begin
            errors++; $display("FAIL route_resp0 got v=%b res=%h cnt=%0d want 01/bb/1", resp_valid, resp_result, outst_cnt); end
        step();
        clear_inputs();
        #1;
        checks++; if ({outst_cnt, idle} !== {4'd0, 1'b1}) begin
            errors++; $display("FAIL route_drain got cnt=%0d idle=%b want 0/1", outst_cnt, idle); end
    endtask

    task automatic test_backpressure();
        req_insn[0] = 32'h0000_00E0; req_insn[1] = 32'h0000_00E1;
        acc_req_ready = 1'b1;
        req_valid = 2'b01; req_resp_exp = 2'b01;
        repeat (8) step();
        #1;
        checks++; if (outst_cnt !== 4'd8) begin errors++; $display("FAIL bp_full got %0d want 8", outst_cnt); end
        req_valid = 2'b11;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if ({req_ready, acc_insn} !== {2'b10, 32'h0000_00E1}) begin
                errors++; $display("FAIL bp_blocked cycle %0d got rdy=%b insn=%h want 10/000000e1", c, req_ready, acc_insn);
            end
            step();
        end
        req_valid = 2'b01; acc_resp_valid = 1'b1; resp_ready = 2'b01;
        #1;
        checks++; if ({acc_req_valid, req_ready, resp_valid} !== {1'b0, 2'b00, 2'b01}) begin
            errors++; $display("FAIL bp_pop_cycle got v=%b rdy=%b rv=%b want 0/00/01", acc_req_valid, req_ready, resp_valid); end
        step();
        acc_resp_valid = 1'b0;
        #1;
        checks++; if ({req_ready, outst_cnt} !== {2'b01, 4'd7}) begin
            errors++; $display("FAIL bp_unblock got rdy=%b cnt=%0d want 01/7", req_ready, outst_cnt); end
        step();
        req_valid = 2'b00; req_resp_exp = 2'b00;
        #1;
        checks++; if (outst_cnt !== 4'd8) begin errors++; $display("FAIL bp_refill got %0d want 8", outst_cnt); end
        acc_resp_valid = 1'b1;
        repeat (8) step();
        clear_inputs();
        #1;
        checks++; if (outst_cnt !== 4'd0) begin errors++; $display("FAIL bp_drain got %0d want 0", outst_cnt); end
    endtask

    task automatic test_spurious_reset();
        acc_resp_valid = 1'b1; resp_ready = 2'b00;
        #1;
        checks++; if ({acc_resp_ready, resp_valid} !== {1'b1, 2'b00}) begin
            errors++; $display("FAIL spur_sink got rdy=%b rv=%b want 1/00", acc_resp_ready, resp_valid); end
        step();
        acc_resp_valid = 1'b0;
        step();
        checks++; if (err_spurious !== 1'b1) begin errors++; $display("FAIL spur_sticky got %b want 1", err_spurious); end
        acc_req_ready = 1'b1; req_valid = 2'b01; req_resp_exp = 2'b01;
        repeat (3) step();
        #1;
        checks++; if (outst_cnt !== 4'd3) begin errors++; $display("FAIL rst_pre_cnt got %0d want 3", outst_cnt); end
        #1;
        rst_n = 1'b0;
        clear_inputs();
        #1;
        checks++; if ({outst_cnt, err_spurious, idle, acc_req_valid} !== {4'd0, 1'b0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL rst_mid got cnt=%0d err=%b idle=%b v=%b want 0/0/1/0", outst_cnt, err_spurious, idle, acc_req_valid); end
        step();
        rst_n = 1'b1;
        step();
        checks++; if ({outst_cnt, idle} !== {4'd0, 1'b1}) begin
            errors++; $display("FAIL rst_after got cnt=%0d idle=%b want 0/1", outst_cnt, idle); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_lock();
        test_routing();
        test_backpressure();
        test_spurious_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
